oam_dma: RTL and testbench

// - OAM DMA engine: the initiator on the PPU's OAM write port.
// - A CPU write to FF46 (ctrl addr 7'h46) copies NUM_BYTES bytes from {page,8'h00} into OAM.
// - Reads the source over a registered-read system bus and writes OAM entries 0..NUM_BYTES-1.
// - Sits beside the PPU on the shared ctrl bus; top level muxes ctrl_data_out and blocks CPU OAM access while oam_busy.

---
 rtl/gb_pkg.sv | 15 +
 rtl/oam_dma.sv | 97 +++++++++
 tb/tb_oam_dma.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_pkg.sv
// Shared definitions for the Game Boy video blocks: register addresses,
// OAM geometry and the DMA engine state encoding.
package gb_pkg;

  typedef enum logic [1:0] {DMA_IDLE, DMA_START, DMA_XFER} dma_state_t;

  localparam logic [6:0] REG_DMA   = 7'h46;
  localparam int         OAM_BYTES = 160;

  // E0-FF pages mirror C0-DF (echo RAM), so the DMA reads the real WRAM page.
  function automatic logic [7:0] echo_page(input logic [7:0] page);
    return (page >= 8'hE0) ? page - 8'h20 : page;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: a write to FF46 copies NUM_BYTES bytes from {page,00}
// into OAM, one byte per CYCLES_PER_BYTE clocks, after START_DELAY idle clocks.
module oam_dma
  import gb_pkg::*;
#(
  parameter int NUM_BYTES       = OAM_BYTES,
  parameter int CYCLES_PER_BYTE = 4,
  parameter int START_DELAY     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  ctrl_addr,
  input  logic        ctrl_enable,
  input  logic        ctrl_write,
  input  logic [7:0]  ctrl_data_in,
  output logic [7:0]  ctrl_data_out,
  output logic [15:0] src_addr,
  output logic        src_enable,
  input  logic [7:0]  src_data_in,
  output logic [7:0]  oam_addr,
  output logic        oam_enable,
  output logic        oam_write,
  output logic [7:0]  oam_data_out,
  output logic        oam_busy
);

  localparam int PW = $clog2(CYCLES_PER_BYTE);
  localparam int CW = $clog2(START_DELAY + 1);
  localparam logic [7:0]    LAST_IDX  = 8'(NUM_BYTES - 1);
  localparam logic [PW-1:0] LAST_PH   = PW'(CYCLES_PER_BYTE - 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(START_DELAY - 1);

  dma_state_t    state;
  logic [7:0]    reg_dma;
  logic [7:0]    page;
  logic [7:0]    idx;
  logic [PW-1:0] phase;
  logic [CW-1:0] cnt;
  logic          dma_wr;

  assign dma_wr = ctrl_enable & ctrl_write & (ctrl_addr == REG_DMA);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= DMA_IDLE;
      reg_dma       <= 8'hFF;
      ctrl_data_out <= 8'hFF;
      page          <= 8'h00;
      idx           <= 8'h00;
      phase         <= '0;
      cnt           <= '0;
    end else begin
      if (ctrl_enable && !ctrl_write)
        ctrl_data_out <= (ctrl_addr == REG_DMA) ? reg_dma : 8'hFF;

      // A write always (re)starts from entry 0, even mid-transfer.
      if (dma_wr) begin
        reg_dma <= ctrl_data_in;
        page    <= echo_page(ctrl_data_in);
        state   <= DMA_START;
        cnt     <= '0;
        idx     <= 8'h00;
        phase   <= '0;
      end else begin
        case (state)
          DMA_START: begin
            if (cnt == LAST_WAIT) state <= DMA_XFER;
            else                  cnt   <= cnt + 1'b1;
          end
          DMA_XFER: begin
            if (phase == LAST_PH) begin
              // idx is left at the last entry so oam_addr/src_addr hold when idle.
              if (idx == LAST_IDX) begin
                state <= DMA_IDLE;
              end else begin
                idx   <= idx + 8'd1;
                phase <= '0;
              end
            end else begin
              phase <= phase + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign src_enable   = (state == DMA_XFER) && (phase == '0);
  assign src_addr     = {page, idx};
  assign oam_enable   = (state == DMA_XFER) && (phase == PW'(1));
  assign oam_write    = oam_enable;
  assign oam_addr     = idx;
  assign oam_data_out = src_data_in;
  assign oam_busy     = (state != DMA_IDLE);

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: a timing model derived from elapsed cycles
// since the last FF46 write predicts every strobe, address and data byte.
module tb_oam_dma;

  localparam int NB    = 160;
  localparam int CPB   = 4;
  localparam int SD    = 4;
  localparam int TOTAL = SD + NB * CPB;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  ctrl_addr = '0;
  logic        ctrl_enable = 1'b0;
  logic        ctrl_write = 1'b0;
  logic [7:0]  ctrl_data_in = '0;
  logic [7:0]  ctrl_data_out;
  logic [15:0] src_addr;
  logic        src_enable;
  logic [7:0]  src_data_in = '0;
  logic [7:0]  oam_addr;
  logic        oam_enable;
  logic        oam_write;
  logic [7:0]  oam_data_out;
  logic        oam_busy;

  oam_dma #(.NUM_BYTES(NB), .CYCLES_PER_BYTE(CPB), .START_DELAY(SD)) dut (
    .clk(clk), .reset_n(reset_n),
    .ctrl_addr(ctrl_addr), .ctrl_enable(ctrl_enable), .ctrl_write(ctrl_write),
    .ctrl_data_in(ctrl_data_in), .ctrl_data_out(ctrl_data_out),
    .src_addr(src_addr), .src_enable(src_enable), .src_data_in(src_data_in),
    .oam_addr(oam_addr), .oam_enable(oam_enable), .oam_write(oam_write),
    .oam_data_out(oam_data_out), .oam_busy(oam_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source memory contents; page C1 yields i^5A.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    logic [7:0] hi;
    hi = a[15:8] + 8'h3F;
    return a[7:0] ^ 8'h5A ^ hi;
  endfunction

  function automatic logic [7:0] eff(input logic [7:0] p);
    return (p >= 8'hE0) ? p - 8'h20 : p;
  endfunction

  // Registered-read source bus and OAM storage.
  logic [7:0] oam [0:255];
  always @(posedge clk) begin
    if (src_enable) src_data_in <= mem_byte(src_addr);
    if (oam_write)  oam[oam_addr] <= oam_data_out;
  end

  // Reference model: time of last FF46 write and the register view.
  int         cyc = 0;
  int         t0 = 0;
  bit         active = 0;
  logic [7:0] mpage = '0;
  logic [7:0] mreg = 8'hFF;
  logic [7:0] mout = 8'hFF;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active <= 0;
      mreg   <= 8'hFF;
      mout   <= 8'hFF;
    end else begin
      if (ctrl_enable && !ctrl_write)
        mout <= (ctrl_addr == 7'h46) ? mreg : 8'hFF;
      if (ctrl_enable && ctrl_write && ctrl_addr == 7'h46) begin
        mreg   <= ctrl_data_in;
        mpage  <= eff(ctrl_data_in);
        active <= 1;
        t0     <= cyc;
      end
    end
  end

  bit mon_en = 0;
  int busy_cnt = 0;

  always @(negedge clk) begin : mon
    int el, off, k;
    bit eb, es, eo;
    if (mon_en) begin
      el = cyc - t0;
      eb = active && el >= 1 && el <= TOTAL;
      es = 0; eo = 0; k = 0;
      if (eb && el >= SD + 1) begin
        off = el - SD - 1;
        k   = off / CPB;
        es  = (off % CPB) == 0;
        eo  = (off % CPB) == 1;
      end
      chk("busy", oam_busy, eb);
      chk("src_enable", src_enable, es);
      chk("oam_write", oam_write, eo);
      chk("oam_enable", oam_enable, eo);
      chk("ctrl_data_out", ctrl_data_out, mout);
      if (es) chk("src_addr", src_addr, {mpage, k[7:0]});
      if (eo) begin
        chk("oam_addr", oam_addr, k[7:0]);
        chk("oam_data", oam_data_out, mem_byte({mpage, k[7:0]}));
      end
      if (oam_busy) busy_cnt++;
    end
  end

  task automatic do_write(input logic [7:0] p);
    ctrl_enable = 1; ctrl_write = 1; ctrl_addr = 7'h46; ctrl_data_in = p;
    @(negedge clk);
    ctrl_enable = 0; ctrl_write = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && oam_busy; i++) @(negedge clk);
    chk("idle_timeout", oam_busy, 0);
  endtask

  task automatic chk_page(input string name, input logic [7:0] p);
    int bad = 0;
    for (int i = 0; i < NB; i++) begin
      logic [15:0] a;
      a = {p, i[7:0]};
      if (oam[i] !== mem_byte(a)) bad++;
    end
    chk(name, bad, 0);
  endtask

  typedef struct {
    logic       en;
    logic       wr;
    logic [6:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] last;
    vecs[0] = '{1'b1, 1'b0, 7'h46, 8'h00, 8'hFF};
    vecs[1] = '{1'b1, 1'b0, 7'h40, 8'h00, 8'hFF};
    vecs[2] = '{1'b1, 1'b1, 7'h47, 8'h33, 8'hFF};
    vecs[3] = '{1'b1, 1'b0, 7'h47, 8'h00, 8'hFF};
    vecs[4] = '{1'b1, 1'b0, 7'h46, 8'h00, 8'hFF};
    vecs[5] = '{1'b1, 1'b1, 7'h46, 8'hA5, 8'hFF};
    vecs[6] = '{1'b1, 1'b0, 7'h46, 8'h00, 8'hA5};
    vecs[7] = '{1'b0, 1'b0, 7'h40, 8'h00, 8'hA5};
    vecs[8] = '{1'b1, 1'b0, 7'h40, 8'h00, 8'hFF};
    vecs[9] = '{1'b1, 1'b0, 7'h46, 8'h00, 8'hA5};

    repeat (3) @(negedge clk);
    reset_n = 1;
    mon_en  = 1;
    chk("rst_ctrl_out", ctrl_data_out, 8'hFF);
    chk("rst_src_addr", src_addr, 16'h0000);
    chk("rst_oam_addr", oam_addr, 8'h00);
    chk("rst_busy", oam_busy, 0);

    // Control decode table
    for (int i = 0; i < 10; i++) begin
      ctrl_enable = vecs[i].en; ctrl_write = vecs[i].wr;
      ctrl_addr = vecs[i].addr; ctrl_data_in = vecs[i].data;
      @(negedge clk);
      chk($sformatf("vec%0d", i), ctrl_data_out, vecs[i].exp);
    end
    ctrl_enable = 0; ctrl_write = 0;
    wait_idle();

    // Basic copy from page C1
    busy_cnt = 0;
    do_write(8'hC1);
    wait_idle();
    chk("busy_cycles", busy_cnt, TOTAL);
    chk_page("copy_c1", 8'hC1);
    chk("copy_c1_e0", oam[0], 8'h5A);
    chk("copy_c1_e159", oam[159], 8'd159 ^ 8'h5A);

    // Echo alias page
    do_write(8'hE3);
    wait_idle();
    chk_page("echo_e3", 8'hC3);

    // Restart at idx 50
    do_write(8'hC0);
    repeat (SD + 50 * CPB) @(negedge clk);
    chk("restart_at_idx50", src_addr, 16'hC032);
    do_write(8'hD0);
    for (int i = 0; i < SD; i++) begin
      chk("restart_gap", src_enable, 0);
      @(negedge clk);
    end
    chk("restart_src_en", src_enable, 1);
    chk("restart_src_addr", src_addr, 16'hD000);
    wait_idle();
    chk_page("restart_d0", 8'hD0);

    // Randomized pages, reads and occasional restarts
    for (int it = 0; it < 6; it++) begin
      int n;
      last = 8'($urandom);
      do_write(last);
      n = $urandom_range(100, 800);
      for (int c = 0; c < n; c++) begin
        if ($urandom_range(0, 299) == 0) begin
          last = 8'($urandom);
          do_write(last);
        end else begin
          ctrl_enable = 1'($urandom);
          ctrl_write  = 0;
          case ($urandom_range(0, 3))
            0: ctrl_addr = 7'h46;
            1: ctrl_addr = 7'h40;
            2: ctrl_addr = 7'h47;
            default: ctrl_addr = 7'($urandom);
          endcase
          @(negedge clk);
        end
      end
      ctrl_enable = 0;
      wait_idle();
      chk_page($sformatf("rand%0d", it), eff(last));
    end

    // Mid-transfer asynchronous reset
    do_write(8'hC1);
    repeat (100) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 0;
    #1;
    chk("arst_src_en", src_enable, 0);
    chk("arst_oam_wr", oam_write, 0);
    chk("arst_busy", oam_busy, 0);
    chk("arst_ctrl_out", ctrl_data_out, 8'hFF);
    @(negedge clk);
    reset_n = 1;
    chk("arst_partial_e10", oam[10], 8'd10 ^ 8'h5A);
    chk("arst_untouched_e150", oam[150], mem_byte({eff(last), 8'd150}));
    ctrl_enable = 1; ctrl_write = 0; ctrl_addr = 7'h46;
    @(negedge clk);
    ctrl_enable = 0;
    chk("arst_read46", ctrl_data_out, 8'hFF);
    repeat (10) @(negedge clk);
    chk("arst_stays_idle", oam_busy, 0);

    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
